// File: rtl/tx_link_ctrl_8b10b.sv
// Transmit link sequencer feeding an 8b10b encoder, one symbol per clock.
// Handles comma training after reset or on request. Frames packets from a
// byte source as SOP / data / EOP. Fills gaps with K28.0. Forces a K28.5
// comma whenever the run of non-comma symbols reaches ALIGN_PERIOD-1.
//
// Handshake: a byte transfers on a rising edge where s_valid && s_ready.
// s_ready never depends on s_valid. Once s_valid is raised, the source
// holds s_data/s_last until that transfer happens. The accepted byte is on
// enc_data after that same edge.
module tx_link_ctrl_8b10b #(
   parameter int TRAIN_LEN    = 64,
   parameter int ALIGN_PERIOD = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        train_req,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   output logic [7:0]  enc_data,
   output logic        enc_k_en,
   output logic        link_up,
   output logic [15:0] pkt_cnt
);

   localparam logic [7:0] SYM_COMMA = 8'hBC;  // K28.5
   localparam logic [7:0] SYM_SOP   = 8'hFB;  // K27.7
   localparam logic [7:0] SYM_EOP   = 8'hFD;  // K29.7
   localparam logic [7:0] SYM_FILL  = 8'h1C;  // K28.0

   localparam int TW = (TRAIN_LEN > 2) ? $clog2(TRAIN_LEN) : 1;
   localparam int RW = $clog2(ALIGN_PERIOD + 1);

   localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_LEN - 1);
   localparam logic [RW-1:0] RUN_MAX    = RW'(ALIGN_PERIOD);
   localparam logic [RW-1:0] RUN_DUE    = RW'(ALIGN_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_TRAIN = 2'd0,
      ST_IDLE  = 2'd1,
      ST_DATA  = 2'd2,
      ST_EOP   = 2'd3
   } state_t;

   state_t         state, state_nxt;
   logic [TW-1:0]  train_cnt, train_cnt_nxt;
   logic [RW-1:0]  run_cnt, run_cnt_nxt;
   logic [7:0]     data_nxt;
   logic           k_nxt;
   logic           link_up_nxt;
   logic [15:0]    pkt_cnt_nxt;
   logic           align_due;

   // The next symbol would exceed the allowed non-comma run unless a comma goes out now.
   assign align_due = (run_cnt >= RUN_DUE);

   // Accept only while framing data with no alignment comma or retrain pending.
   assign s_ready = (state == ST_DATA) && !align_due && !train_req && !rst;

   // Choose the next symbol and sequencer state. Everything defaults to idling with a comma.
   always_comb begin
      state_nxt     = state;
      train_cnt_nxt = train_cnt;
      data_nxt      = SYM_COMMA;
      k_nxt         = 1'b1;
      link_up_nxt   = link_up;
      pkt_cnt_nxt   = pkt_cnt;
      run_cnt_nxt   = run_cnt;

      if (train_req) begin
         // Any in-flight packet is dropped without an EOP.
         state_nxt     = ST_TRAIN;
         train_cnt_nxt = '0;
         link_up_nxt   = 1'b0;
      end else begin
         case (state)
            ST_TRAIN: begin
               train_cnt_nxt = train_cnt + TW'(1);
               if (train_cnt == TRAIN_LAST) begin
                  train_cnt_nxt = '0;
                  state_nxt     = ST_IDLE;
                  link_up_nxt   = 1'b1;
               end
            end
            ST_IDLE: begin
               // SOP only announces the packet; the first byte is taken in DATA.
               if (!align_due && s_valid) begin
                  data_nxt  = SYM_SOP;
                  state_nxt = ST_DATA;
               end
            end
            ST_DATA: begin
               if (!align_due) begin
                  if (s_valid) begin
                     data_nxt = s_data;
                     k_nxt    = 1'b0;
                     if (s_last) state_nxt = ST_EOP;
                  end else begin
                     data_nxt = SYM_FILL;
                  end
               end
            end
            ST_EOP: begin
               // EOP is never held back for alignment. The IDLE cycle after it sends the comma.
               data_nxt    = SYM_EOP;
               pkt_cnt_nxt = pkt_cnt + 16'd1;
               state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_TRAIN;
         endcase
      end

      // A data byte equal to 0xBC is not a comma; only K28.5 restarts the run.
      if (k_nxt && (data_nxt == SYM_COMMA)) begin
         run_cnt_nxt = '0;
      end else if (run_cnt != RUN_MAX) begin
         run_cnt_nxt = run_cnt + RW'(1);
      end
   end

   // Register the symbol, the counters and the sequencer state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_TRAIN;
         train_cnt <= '0;
         run_cnt   <= '0;
         enc_data  <= SYM_COMMA;
         enc_k_en  <= 1'b1;
         link_up   <= 1'b0;
         pkt_cnt   <= 16'd0;
      end else begin
         state     <= state_nxt;
         train_cnt <= train_cnt_nxt;
         run_cnt   <= run_cnt_nxt;
         enc_data  <= data_nxt;
         enc_k_en  <= k_nxt;
         link_up   <= link_up_nxt;
         pkt_cnt   <= pkt_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_tx_link_ctrl_8b10b.sv
// Directed bench for tx_link_ctrl_8b10b with TRAIN_LEN=4 and ALIGN_PERIOD=8.
// A per-cycle vector table covers training, framing, underrun, back-to-back
// packets, EOP at the alignment limit, and retraining mid-packet. A 20-byte
// packet then checks periodic comma insertion against an expected symbol queue.
module tb_tx_link_ctrl_8b10b;

   logic        clk;
   logic        rst;
   logic        train_req;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;
   logic [7:0]  enc_data;
   logic        enc_k_en;
   logic        link_up;
   logic [15:0] pkt_cnt;

   int checks = 0;
   int errors = 0;

   tx_link_ctrl_8b10b #(.TRAIN_LEN(4), .ALIGN_PERIOD(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .train_req (train_req),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_last    (s_last),
      .s_ready   (s_ready),
      .enc_data  (enc_data),
      .enc_k_en  (enc_k_en),
      .link_up   (link_up),
      .pkt_cnt   (pkt_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        tr;
      logic        v;
      logic [7:0]  d;
      logic        l;
      logic        rdy;
      logic [7:0]  ed;
      logic        ek;
      logic        up;
      logic [15:0] pc;
   } vec_t;

   vec_t        vq[$];
   logic [8:0]  exp_q[$];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic add(input logic tr, input logic v, input logic [7:0] d, input logic l,
                      input logic rdy, input logic [7:0] ed, input logic ek,
                      input logic up, input logic [15:0] pc);
      vec_t x;
      x.tr = tr; x.v = v; x.d = d; x.l = l;
      x.rdy = rdy; x.ed = ed; x.ek = ek; x.up = up; x.pc = pc;
      vq.push_back(x);
   endtask

   logic [7:0] pkt [20];
   int         idx;
   int         hs;
   logic       rdy_s;
   logic [8:0] exp_sym;

   initial begin
      rst = 1'b1; train_req = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;

      //            tr v  d      l  rdy ed     k  up pc
      // training: 4 commas, link_up on the 4th
      add(0, 0, 8'h00, 0, 0, 8'hBC, 1, 0, 0);
      add(0, 0, 8'h00, 0, 0, 8'hBC, 1, 0, 0);
      add(0, 0, 8'h00, 0, 0, 8'hBC, 1, 0, 0);
      add(0, 0, 8'h00, 0, 0, 8'hBC, 1, 1, 0);
      add(0, 0, 8'h00, 0, 0, 8'hBC, 1, 1, 0);
      add(0, 0, 8'h00, 0, 0, 8'hBC, 1, 1, 0);
      // packet 00 01 02
      add(0, 1, 8'h00, 0, 0, 8'hFB, 1, 1, 0);
      add(0, 1, 8'h00, 0, 1, 8'h00, 0, 1, 0);
      add(0, 1, 8'h01, 0, 1, 8'h01, 0, 1, 0);
      add(0, 1, 8'h02, 1, 1, 8'h02, 0, 1, 0);
      add(0, 0, 8'h00, 0, 0, 8'hFD, 1, 1, 1);
      add(0, 0, 8'h00, 0, 0, 8'hBC, 1, 1, 1);
      // packet 10 . . 11 12 with two underrun fills
      add(0, 1, 8'h10, 0, 0, 8'hFB, 1, 1, 1);
      add(0, 1, 8'h10, 0, 1, 8'h10, 0, 1, 1);
      add(0, 0, 8'h00, 0, 1, 8'h1C, 1, 1, 1);
      add(0, 0, 8'h00, 0, 1, 8'h1C, 1, 1, 1);
      add(0, 1, 8'h11, 0, 1, 8'h11, 0, 1, 1);
      add(0, 1, 8'h12, 1, 1, 8'h12, 0, 1, 1);
      // EOP leaves the run at 7, so the following IDLE must send a comma even with s_valid high
      add(0, 0, 8'h00, 0, 0, 8'hFD, 1, 1, 2);
      add(0, 1, 8'h20, 0, 0, 8'hBC, 1, 1, 2);
      // back-to-back packets 20 21 | 30
      add(0, 1, 8'h20, 0, 0, 8'hFB, 1, 1, 2);
      add(0, 1, 8'h20, 0, 1, 8'h20, 0, 1, 2);
      add(0, 1, 8'h21, 1, 1, 8'h21, 0, 1, 2);
      add(0, 1, 8'h30, 1, 0, 8'hFD, 1, 1, 3);
      add(0, 1, 8'h30, 1, 0, 8'hFB, 1, 1, 3);
      add(0, 1, 8'h30, 1, 1, 8'h30, 0, 1, 3);
      add(0, 0, 8'h00, 0, 0, 8'hFD, 1, 1, 4);
      add(0, 0, 8'h00, 0, 0, 8'hBC, 1, 1, 4);
      // retrain mid-packet: no EOP, 4 more commas, pkt_cnt unchanged
      add(0, 1, 8'h40, 0, 0, 8'hFB, 1, 1, 4);
      add(0, 1, 8'h40, 0, 1, 8'h40, 0, 1, 4);
      add(1, 1, 8'h41, 0, 0, 8'hBC, 1, 0, 4);
      add(0, 0, 8'h00, 0, 0, 8'hBC, 1, 0, 4);
      add(0, 0, 8'h00, 0, 0, 8'hBC, 1, 0, 4);
      add(0, 0, 8'h00, 0, 0, 8'hBC, 1, 0, 4);
      add(0, 0, 8'h00, 0, 0, 8'hBC, 1, 1, 4);
      add(0, 0, 8'h00, 0, 0, 8'hBC, 1, 1, 4);

      // reset state
      @(posedge clk);
      @(posedge clk); #1;
      chk("rst_data",  {8'h00, enc_data}, 16'h00BC);
      chk("rst_k",     {15'd0, enc_k_en}, 16'd1);
      chk("rst_up",    {15'd0, link_up},  16'd0);
      chk("rst_pc",    pkt_cnt,           16'd0);
      chk("rst_ready", {15'd0, s_ready},  16'd0);
      @(negedge clk);
      rst = 1'b0;

      // table-driven vectors, one per clock
      for (int i = 0; i < vq.size(); i++) begin
         train_req = vq[i].tr;
         s_valid   = vq[i].v;
         s_data    = vq[i].d;
         s_last    = vq[i].l;
         #1;
         chk($sformatf("v%0d_ready", i), {15'd0, s_ready}, {15'd0, vq[i].rdy});
         @(posedge clk); #1;
         chk($sformatf("v%0d_data", i), {8'h00, enc_data}, {8'h00, vq[i].ed});
         chk($sformatf("v%0d_k", i),    {15'd0, enc_k_en}, {15'd0, vq[i].ek});
         chk($sformatf("v%0d_up", i),   {15'd0, link_up},  {15'd0, vq[i].up});
         chk($sformatf("v%0d_pc", i),   pkt_cnt,           vq[i].pc);
         @(negedge clk);
      end
      train_req = 1'b0;

      // 20-byte packet: commas after SOP+6 bytes and after 7 more bytes
      for (int i = 0; i < 20; i++) pkt[i] = 8'h50 + 8'(i);
      exp_q.push_back({1'b1, 8'hFB});
      for (int i = 0; i < 6; i++)   exp_q.push_back({1'b0, pkt[i]});
      exp_q.push_back({1'b1, 8'hBC});
      for (int i = 6; i < 13; i++)  exp_q.push_back({1'b0, pkt[i]});
      exp_q.push_back({1'b1, 8'hBC});
      for (int i = 13; i < 20; i++) exp_q.push_back({1'b0, pkt[i]});
      exp_q.push_back({1'b1, 8'hFD});
      exp_q.push_back({1'b1, 8'hBC});

      idx = 0;
      hs  = 0;
      for (int cyc = 0; cyc < 25; cyc++) begin
         s_valid = (idx < 20);
         s_data  = (idx < 20) ? pkt[idx] : 8'h00;
         s_last  = (idx == 19);
         exp_sym = exp_q.pop_front();
         #1;
         rdy_s = s_ready;
         chk($sformatf("long%0d_ready", cyc), {15'd0, rdy_s}, {15'd0, ~exp_sym[8]});
         @(posedge clk); #1;
         if (s_valid && rdy_s) begin
            idx++;
            hs++;
         end
         chk($sformatf("long%0d_sym", cyc), {7'd0, enc_k_en, enc_data}, {7'd0, exp_sym});
         @(negedge clk);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      chk("long_handshakes", 16'(hs), 16'd20);
      chk("long_pc", pkt_cnt, 16'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
